// File: rtl/class2_feature_loader.sv
// Byte-serial assembler for the class2_tree feature vector. Collects NB bytes
// into an assembly register and hands complete frames to a double-buffered output.
module class2_feature_loader #(
  parameter int NFEAT = 51
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_sof,
  output logic             feat_valid,
  input  logic             feat_ready,
  output logic [NFEAT-1:0] feat,
  output logic [7:0]       err_count,
  output logic             busy
);

  localparam int NB    = (NFEAT + 7) / 8;
  localparam int CW    = $clog2(NB);
  localparam int LASTW = NFEAT - 8 * (NB - 1);
  // Bits of the last byte that lie beyond NFEAT and must arrive as zero.
  localparam logic [7:0] PAD_MASK = ~8'((16'd1 << LASTW) - 16'd1);

  typedef enum logic [1:0] {WAIT_SOF, COLLECT, FULL} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [NFEAT-1:0]  asm_q;
  logic [8*NB-1:0]   wr_vec;
  logic [CW-1:0]     wr_idx;
  logic              acc, slot_free, last, pad_bad;
  logic              take_sof, stray, mid, fin, fin_ok, err_evt, load;
  logic [NFEAT-1:0]  load_vec;

  assign acc       = in_valid && in_ready;
  assign slot_free = !feat_valid || feat_ready;
  assign last      = (cnt == CW'(NB - 1));
  assign pad_bad   = |(in_data & PAD_MASK);
  assign wr_idx    = in_sof ? '0 : cnt;

  // Assembly register with the incoming byte merged in at its slot.
  always_comb begin
    wr_vec = '0;
    wr_vec[NFEAT-1:0] = asm_q;
    wr_vec[8*int'(wr_idx) +: 8] = in_data;
  end

  always_comb begin
    take_sof = acc && in_sof;
    stray    = acc && !in_sof && (state == WAIT_SOF);
    mid      = acc && !in_sof && (state == COLLECT) && !last;
    fin      = acc && !in_sof && (state == COLLECT) && last;
    fin_ok   = fin && !pad_bad;
    err_evt  = stray || (take_sof && state == COLLECT) || (fin && pad_bad);
    load     = slot_free && (fin_ok || state == FULL);
    load_vec = (state == FULL) ? asm_q : wr_vec[NFEAT-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_SOF;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOF: if (take_sof) state_nxt = COLLECT;
      COLLECT:  if (fin) state_nxt = (pad_bad || slot_free) ? WAIT_SOF : FULL;
      FULL:     if (slot_free) state_nxt = WAIT_SOF;
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  always_comb begin
    in_ready = (state != FULL);
    busy     = (state != WAIT_SOF) || feat_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      cnt        <= '0;
      feat       <= '0;
      feat_valid <= 1'b0;
      err_count  <= '0;
    end else begin
      // Last byte is parked in asm_q only when the output slot is occupied.
      if (take_sof || mid || (fin_ok && !slot_free)) asm_q <= wr_vec[NFEAT-1:0];
      if (take_sof)  cnt <= CW'(1);
      else if (mid)  cnt <= cnt + CW'(1);
      else if (fin)  cnt <= '0;
      if (load) begin
        feat       <= load_vec;
        feat_valid <= 1'b1;
      end else if (feat_ready) begin
        feat_valid <= 1'b0;
      end
      if (err_evt && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_class2_feature_loader.sv
// Directed bench for class2_feature_loader: framing, backpressure, resync,
// pad errors, error saturation and asynchronous reset.
module tb_class2_feature_loader;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_sof;
  logic [7:0]  in_data;
  logic        feat_valid, feat_ready, busy;
  logic [50:0] feat;
  logic [7:0]  err_count;
  int          n_cmp, n_bad;

  class2_feature_loader #(.NFEAT(51)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat(feat),
    .err_count(err_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic put(input logic [7:0] d, input logic s);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_sof = s;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("put_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [55:0] v);
    for (int k = 0; k < 7; k++) put(v[8*k +: 8], k == 0);
  endtask

  logic [55:0] f;
  logic        seen;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; feat_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_feat_valid", 64'(feat_valid), 64'd0);
    chk("rst_feat",       64'(feat),       64'd0);
    chk("rst_err",        64'(err_count),  64'd0);
    chk("rst_in_ready",   64'(in_ready),   64'd1);
    chk("rst_busy",       64'(busy),       64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame
    feat_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) chk("basic_pre_valid", 64'(feat_valid), 64'd0);
      put(8'(k + 1), k == 0);
    end
    chk("basic_valid", 64'(feat_valid), 64'd1);
    chk("basic_feat",  64'(feat), 64'h7060504030201);
    chk("basic_err",   64'(err_count), 64'd0);
    @(negedge clk);
    chk("basic_one_cycle", 64'(feat_valid), 64'd0);

    // Backpressure
    feat_ready = 1'b0;
    send_frame(56'h05_66_55_44_33_22_11);
    chk("bp_f1_valid", 64'(feat_valid), 64'd1);
    chk("bp_f1_feat",  64'(feat), 64'h5665544332211);
    send_frame(56'h03_A6_A5_A4_A3_A2_A1);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_f1_held",    64'(feat), 64'h5665544332211);
    in_valid = 1'b1; in_data = 8'hC1; in_sof = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_stall_ready", 64'(in_ready), 64'd0);
    chk("bp_stall_feat",  64'(feat), 64'h5665544332211);
    chk("bp_busy",        64'(busy), 64'd1);
    feat_ready = 1'b1;
    @(negedge clk);
    feat_ready = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    chk("bp_f2_feat",  64'(feat), 64'h3A6A5A4A3A2A1);
    chk("bp_f2_valid", 64'(feat_valid), 64'd1);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    feat_ready = 1'b1;
    send_frame(56'h07_C7_C6_C5_C4_C3_C2);
    chk("bp_f3_valid", 64'(feat_valid), 64'd1);
    chk("bp_f3_feat",  64'(feat), 64'h7C7C6C5C4C3C2);
    chk("bp_err",      64'(err_count), 64'd0);
    @(negedge clk);

    // Resync: 3-byte partial frame dropped by a new sof
    put(8'hAA, 1'b1); put(8'hBB, 1'b0); put(8'hCC, 1'b0);
    send_frame(56'h06_15_14_13_12_11_10);
    chk("resync_err",   64'(err_count), 64'd1);
    chk("resync_valid", 64'(feat_valid), 64'd1);
    chk("resync_feat",  64'(feat), 64'h6151413121110);
    @(negedge clk);

    // Pad error
    send_frame(56'h08_26_25_24_23_22_21);
    chk("pad_valid", 64'(feat_valid), 64'd0);
    chk("pad_err",   64'(err_count), 64'd2);
    chk("pad_idle",  64'(busy), 64'd0);
    chk("pad_feat_kept", 64'(feat), 64'h6151413121110);
    send_frame(56'h01_36_35_34_33_32_31);
    chk("pad_next_valid", 64'(feat_valid), 64'd1);
    chk("pad_next_feat",  64'(feat), 64'h1363534333231);
    @(negedge clk);

    // Stray bytes and saturation
    seen = 1'b0;
    in_valid = 1'b1; in_sof = 1'b0;
    for (int k = 0; k < 300; k++) begin
      in_data = 8'(k);
      @(negedge clk);
      if (feat_valid) seen = 1'b1;
    end
    in_valid = 1'b0;
    chk("sat_err",   64'(err_count), 64'd255);
    chk("sat_valid", 64'(seen), 64'd0);
    @(negedge clk);
    chk("sat_hold",  64'(err_count), 64'd255);

    // Async reset with feat_valid high and a frame in progress
    feat_ready = 1'b0;
    send_frame(56'h02_46_45_44_43_42_41);
    put(8'h51, 1'b1); put(8'h52, 1'b0);
    chk("ar_pre_valid", 64'(feat_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid",    64'(feat_valid), 64'd0);
    chk("ar_feat",     64'(feat), 64'd0);
    chk("ar_err",      64'(err_count), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_busy",     64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    feat_ready = 1'b1;
    f = 56'h07_06_05_04_03_02_01;
    send_frame(f);
    chk("ar_basic_valid", 64'(feat_valid), 64'd1);
    chk("ar_basic_feat",  64'(feat), 64'h7060504030201);
    chk("ar_basic_err",   64'(err_count), 64'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/class2_feature_loader.md
# class2_feature_loader

Byte-serial feature-frame assembler that sits directly upstream of the `class2_tree*` classifier bank. It collects a 51-bit feature vector from an 8-bit valid/ready stream. It then holds the vector stable on `feat`, which drives the trees' `i[50:0]` input, under a valid/ready handshake. The output register is double-buffered against the assembly register, so a new frame can be assembled while the tree bank consumes the previous one.

## Interface
- `NFEAT`, default 51: feature vector width. The frame length is `NB = ceil(NFEAT/8)` bytes, which is 7 at the default.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: loader can accept a byte.
- `in_data` in 8: feature byte.
- `in_sof` in 1: byte is the first byte of a frame.
- `feat_valid` out 1: `feat` holds a complete frame.
- `feat_ready` in 1: tree bank consumes `feat`.
- `feat` out NFEAT: feature vector, connected to the tree `i`.
- `err_count` out 8: dropped-frame/byte count, saturating.
- `busy` out 1: high when state != WAIT_SOF or `feat_valid` = 1.

## Operation
- A byte is accepted when `in_valid && in_ready`.
- Byte k carries `feat[8k+7:8k]`.
- Pad bits of the last byte (bits `NFEAT..8*NB-1`; bits 7:3 of byte 6 at default) must be 0.
- Storage:
  - Assembly register `asm` (NFEAT bits).
  - Byte counter `cnt` (0..NB-1).
  - Output register `feat` plus `feat_valid`.
- `slot_free` = `!feat_valid || feat_ready`.
- State machine:
  - **WAIT_SOF**: `in_ready` = 1.
    - Accepted byte with `in_sof` = 1: write byte 0, `cnt` = 1, go to COLLECT.
    - Accepted byte with `in_sof` = 0: discard it, increment `err_count`, stay.
  - **COLLECT**: `in_ready` = 1.
    - Accepted byte with `in_sof` = 1: drop the partial frame, increment `err_count`, treat this byte as byte 0 (`cnt` = 1), stay.
    - Accepted byte with `in_sof` = 0 and `cnt` < NB-1: write it at `cnt`, increment `cnt`.
    - Accepted byte with `in_sof` = 0 and `cnt` = NB-1, pad nonzero: drop the frame, increment `err_count`, go to WAIT_SOF.
    - Accepted byte with `in_sof` = 0 and `cnt` = NB-1, pad zero, `slot_free`: load `feat` with the full vector including this byte, set `feat_valid`, go to WAIT_SOF.
    - Same, pad zero, not `slot_free`: go to FULL.
  - **FULL**: `in_ready` = 0. When `slot_free`, load `feat` from `asm`, set `feat_valid`, go to WAIT_SOF.
  - NB = 1 is not supported; NFEAT > 8 is required.
- Output handshake:
  - `feat_valid && feat_ready` clears `feat_valid` unless a load occurs in the same cycle; a load wins and keeps `feat_valid` = 1.
  - `feat` changes only on a load.
  - `feat` is stable while `feat_valid && !feat_ready`.
- `err_count` increments by 1 per event, saturates at 255, and clears only on reset.
- Reset (any time, including mid-frame or with `feat_valid` high):
  - state = WAIT_SOF, `cnt` = 0, `asm` = 0.
  - `feat` = 0, `feat_valid` = 0, `err_count` = 0.
  - `in_ready` = 1, `busy` = 0.
  - The partial frame is lost without counting.

## Timing
- Latency: last byte accepted in cycle t with `slot_free` at t gives `feat_valid` = 1 from t+1.
- From FULL, `slot_free` at cycle t gives the new `feat` at t+1 and `in_ready` = 1 at t+1.
- Sustained throughput: one frame per NB cycles with `feat_ready` held high. There are no bubbles between frames.
- `in_ready` is a registered function of state only. There is no combinational path from `in_valid` to `in_ready`.
- `feat_valid` and `feat` are registered.
- The trees are combinational, so the tree output is valid in the same cycles as `feat_valid`.

## Test plan
- **Basic frame**: after reset, send bytes 0x01..0x07 (sof on the first) with `feat_ready` = 1. Expect `feat` = 51'h7060504030201 and `feat_valid` high exactly one cycle, starting the cycle after byte 7. `err_count` = 0.
- **Backpressure**: hold `feat_ready` = 0 and send two valid frames back-to-back.
  - Frame 1 is held on `feat`. After frame 2's last byte, `in_ready` = 0 and a third frame stalls.
  - Pulse `feat_ready` one cycle. Frame 2 appears on `feat` the next cycle, `in_ready` returns to 1, and frame 3 then completes normally.
- **Resync**: send 3 bytes, then a new sof frame 0x10..0x16. Expect `err_count` = 1 and `feat` = the 0x16..0x10 vector.
- **Pad error**: send a frame whose last byte is 0x08. Expect no `feat_valid`, `err_count` +1, state WAIT_SOF. The next good frame is delivered.
- **Stray bytes and saturation**: send 300 bytes with `in_sof` = 0 in WAIT_SOF. Expect `err_count` = 255 with no wrap and `feat_valid` never asserted.
- **Async reset mid-operation**: drop `rst_n` between clock edges while `feat_valid` = 1 and mid-frame.
  - Expect `feat_valid`, `feat` and `err_count` to go to 0 immediately, and `in_ready` = 1.
  - After release, the basic frame passes.
